// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus between the fetch unit and instruction memory.
// The fetch unit is the master: it raises mem_req with a stable mem_addr and
// memory answers with a one-cycle mem_ack pulse carrying mem_rdata.
interface instr_fetch_unit_if #(
    parameter int AW = 8,
    parameter int IW = 8
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer and instruction register. Reads the word at pc_addr from
// instruction memory, holds it in ir for the decoder (valid/ready) and pulses
// IncPC for INC_HOLD cycles so the program counter advances.
// Optional feature macro: FETCH_TIMEOUT_EN adds a memory wait limit of
// TIMEOUT_CYCLES cycles and a sticky fetch_err flag; without it fetch_err is 0.
module instr_fetch_unit #(
    parameter int AW             = 8,
    parameter int IW             = 8,
    parameter int INC_HOLD       = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                CLK,
    input  logic                CLB,
    input  logic                run,
    input  logic                flush,
    input  logic [AW-1:0]       pc_addr,
    instr_fetch_unit_if.master  mem,
    output logic                IncPC,
    output logic [IW-1:0]       ir,
    output logic [3:0]          opcode,
    output logic [3:0]          operand,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic [7:0]          fetch_count,
    output logic                fetch_err
);

    localparam int INC_W = (INC_HOLD < 2) ? 1 : $clog2(INC_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          load_addr;
    logic          accept;
    logic          timeout;
    logic          drop;
    logic [AW-1:0] addr_q;
    logic [IW-1:0] ir_q;
    logic          ir_valid_q;
    logic [INC_W-1:0] inc_cnt;
    logic [7:0]    count_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 3) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] wait_cnt;
    logic          err_q;

    // Count cycles spent waiting in REQ; any other state clears it so each request starts from zero
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            wait_cnt <= '0;
        end else if (state == REQ) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout = (state == REQ) && !mem.mem_ack &&
                     (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Sticky error flag, only a reset clears it
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; HOLD is left only once the IncPC pulse is on its last cycle so pc_addr has moved on
    always_comb begin
        next_state = state;
        load_addr  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (run && !flush) begin
                    next_state = REQ;
                    load_addr  = 1'b1;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    if (drop || flush) begin
                        next_state = IDLE;
                    end else begin
                        accept     = 1'b1;
                        next_state = HOLD;
                    end
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    next_state = IDLE;
                end else if ((!ir_valid_q || ir_ready) && (inc_cnt <= INC_W'(1))) begin
                    if (run) begin
                        next_state = REQ;
                        load_addr  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request address latch, frozen for the whole request
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            addr_q <= '0;
        end else if (load_addr) begin
            addr_q <= pc_addr;
        end
    end

    // Drop flag marks an in-flight request whose data must be thrown away
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            drop <= 1'b0;
        end else if (state != REQ || mem.mem_ack || timeout) begin
            drop <= 1'b0;
        end else if (flush) begin
            drop <= 1'b1;
        end
    end

    // Instruction register, valid flag, IncPC counter and accepted-fetch counter
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            inc_cnt    <= '0;
            count_q    <= 8'd0;
        end else if (accept) begin
            ir_q       <= mem.mem_rdata;
            ir_valid_q <= 1'b1;
            inc_cnt    <= INC_W'(INC_HOLD);
            count_q    <= count_q + 8'd1;
        end else if (state == HOLD) begin
            if (flush) begin
                ir_valid_q <= 1'b0;
                inc_cnt    <= '0;
            end else begin
                if (ir_valid_q && ir_ready) begin
                    ir_valid_q <= 1'b0;
                end
                if (inc_cnt != '0) begin
                    inc_cnt <= inc_cnt - INC_W'(1);
                end
            end
        end
    end

    assign mem.mem_req  = (state == REQ);
    assign mem.mem_addr = addr_q;
    assign IncPC        = (inc_cnt != '0);
    assign ir           = ir_q;
    assign opcode       = ir_q[IW-1:IW-4];
    assign operand      = ir_q[3:0];
    assign ir_valid     = ir_valid_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. Memory responses and decoder
// readiness are driven by hand; expected values are computed by hand or by a
// small fetch counter model. Honors FETCH_TIMEOUT_EN when defined.
module tb_instr_fetch_unit;

    logic       CLK = 1'b0;
    logic       CLB;
    logic       run;
    logic       flush;
    logic [7:0] pc_addr;
    logic       IncPC;
    logic [7:0] ir;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] fetch_count;
    logic       fetch_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expCount = 8'd0;

    instr_fetch_unit_if #(.AW(8), .IW(8)) memBus ();

    instr_fetch_unit #(
        .AW(8), .IW(8), .INC_HOLD(2), .TIMEOUT_CYCLES(15)
    ) dut (
        .CLK(CLK),
        .CLB(CLB),
        .run(run),
        .flush(flush),
        .pc_addr(pc_addr),
        .mem(memBus.master),
        .IncPC(IncPC),
        .ir(ir),
        .opcode(opcode),
        .operand(operand),
        .ir_valid(ir_valid),
        .ir_ready(ir_ready),
        .fetch_count(fetch_count),
        .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete fetch from IDLE with run dropped after the request; decoder ready
    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
        run     = 1'b1;
        pc_addr = addr;
        tick();
        run                = 1'b0;
        memBus.mem_ack     = 1'b1;
        memBus.mem_rdata   = data;
        tick();
        memBus.mem_ack     = 1'b0;
        expCount           = expCount + 8'd1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        CLB              = 1'b1;
        run              = 1'b0;
        flush            = 1'b0;
        pc_addr          = 8'h00;
        ir_ready         = 1'b0;
        memBus.mem_ack   = 1'b0;
        memBus.mem_rdata = 8'h00;
        #12;
        checkOutput("rst_mem_req", 32'(memBus.mem_req), 32'd0);
        checkOutput("rst_mem_addr", 32'(memBus.mem_addr), 32'd0);
        checkOutput("rst_incpc", 32'(IncPC), 32'd0);
        checkOutput("rst_ir", 32'(ir), 32'd0);
        checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
        checkOutput("rst_count", 32'(fetch_count), 32'd0);
        checkOutput("rst_err", 32'(fetch_err), 32'd0);
        tick();
        CLB = 1'b0;

        // Basic fetch with two-cycle memory latency
        run     = 1'b1;
        pc_addr = 8'h10;
        tick();
        checkOutput("t1_req", 32'(memBus.mem_req), 32'd1);
        checkOutput("t1_addr", 32'(memBus.mem_addr), 32'h10);
        tick();
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 8'hA5;
        tick();
        memBus.mem_ack = 1'b0;
        expCount       = expCount + 8'd1;
        checkOutput("t1_ir", 32'(ir), 32'hA5);
        checkOutput("t1_opcode", 32'(opcode), 32'hA);
        checkOutput("t1_operand", 32'(operand), 32'h5);
        checkOutput("t1_valid", 32'(ir_valid), 32'd1);
        checkOutput("t1_inc_a", 32'(IncPC), 32'd1);
        checkOutput("t1_count", 32'(fetch_count), 32'(expCount));
        checkOutput("t1_req_off", 32'(memBus.mem_req), 32'd0);
        tick();
        checkOutput("t1_inc_b", 32'(IncPC), 32'd1);
        tick();
        checkOutput("t1_inc_c", 32'(IncPC), 32'd0);

        // Decoder stalls: ir held, no new request
        repeat (3) tick();
        checkOutput("t2_hold_valid", 32'(ir_valid), 32'd1);
        checkOutput("t2_hold_ir", 32'(ir), 32'hA5);
        checkOutput("t2_hold_noreq", 32'(memBus.mem_req), 32'd0);
        pc_addr  = 8'h11;
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        checkOutput("t2_req", 32'(memBus.mem_req), 32'd1);
        checkOutput("t2_addr", 32'(memBus.mem_addr), 32'h11);
        checkOutput("t2_valid_off", 32'(ir_valid), 32'd0);
        pc_addr = 8'h22;
        tick();
        checkOutput("t2_addr_frozen", 32'(memBus.mem_addr), 32'h11);

        // Flush during REQ discards the returning data
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        pc_addr = 8'h40;
        tick();
        checkOutput("t3_req_kept", 32'(memBus.mem_req), 32'd1);
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 8'h3C;
        tick();
        memBus.mem_ack = 1'b0;
        checkOutput("t3_ir", 32'(ir), 32'hA5);
        checkOutput("t3_valid", 32'(ir_valid), 32'd0);
        checkOutput("t3_inc", 32'(IncPC), 32'd0);
        checkOutput("t3_count", 32'(fetch_count), 32'(expCount));
        checkOutput("t3_idle", 32'(memBus.mem_req), 32'd0);
        tick();
        checkOutput("t3_req2", 32'(memBus.mem_req), 32'd1);
        checkOutput("t3_addr2", 32'(memBus.mem_addr), 32'h40);
        checkOutput("t3_inc2", 32'(IncPC), 32'd0);

        // Flush coincident with mem_ack
        pc_addr          = 8'h41;
        flush            = 1'b1;
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 8'h77;
        tick();
        flush          = 1'b0;
        memBus.mem_ack = 1'b0;
        checkOutput("t3b_ir", 32'(ir), 32'hA5);
        checkOutput("t3b_valid", 32'(ir_valid), 32'd0);
        checkOutput("t3b_count", 32'(fetch_count), 32'(expCount));
        tick();
        checkOutput("t3b_addr", 32'(memBus.mem_addr), 32'h41);

        // Complete fetch with run dropped during REQ
        run              = 1'b0;
        ir_ready         = 1'b1;
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 8'h5A;
        tick();
        memBus.mem_ack = 1'b0;
        expCount       = expCount + 8'd1;
        checkOutput("t4_ir", 32'(ir), 32'h5A);
        checkOutput("t4_valid", 32'(ir_valid), 32'd1);
        tick();
        checkOutput("t4_consumed", 32'(ir_valid), 32'd0);
        checkOutput("t4_inc_still", 32'(IncPC), 32'd1);
        tick();
        checkOutput("t4_idle_req", 32'(memBus.mem_req), 32'd0);
        checkOutput("t4_idle_inc", 32'(IncPC), 32'd0);
        tick();
        checkOutput("t4_stay_idle", 32'(memBus.mem_req), 32'd0);

        // mem_ack outside REQ is ignored
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 8'hFF;
        tick();
        memBus.mem_ack = 1'b0;
        checkOutput("t5_count", 32'(fetch_count), 32'(expCount));
        checkOutput("t5_ir", 32'(ir), 32'h5A);
        checkOutput("t5_valid", 32'(ir_valid), 32'd0);

        // Flush in HOLD together with ir_ready: flush wins
        ir_ready = 1'b0;
        run      = 1'b1;
        pc_addr  = 8'h50;
        tick();
        run              = 1'b0;
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 8'hC3;
        tick();
        memBus.mem_ack = 1'b0;
        expCount       = expCount + 8'd1;
        checkOutput("t6_inc", 32'(IncPC), 32'd1);
        flush    = 1'b1;
        ir_ready = 1'b1;
        tick();
        flush    = 1'b0;
        ir_ready = 1'b0;
        checkOutput("t6_valid", 32'(ir_valid), 32'd0);
        checkOutput("t6_inc_abort", 32'(IncPC), 32'd0);
        checkOutput("t6_ir_kept", 32'(ir), 32'hC3);
        checkOutput("t6_count", 32'(fetch_count), 32'(expCount));
        tick();
        checkOutput("t6_idle", 32'(memBus.mem_req), 32'd0);

        // Fetch counter wrap
        ir_ready = 1'b1;
        for (int i = 0; i < 252; i++) begin
            applyStimulus(8'(i), 8'(i + 1));
        end
        checkOutput("t7_count255", 32'(fetch_count), 32'h0FF);
        applyStimulus(8'hF0, 8'h96);
        checkOutput("t7_wrap", 32'(fetch_count), 32'(expCount));
        checkOutput("t7_wrap_zero", 32'(fetch_count), 32'd0);
        checkOutput("t7_ir", 32'(ir), 32'h96);

        // Long memory wait: timeout when enabled, indefinite wait otherwise
        run     = 1'b1;
        pc_addr = 8'h60;
        tick();
        run = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (14) tick();
        checkOutput("t8_req_wait", 32'(memBus.mem_req), 32'd1);
        checkOutput("t8_err_before", 32'(fetch_err), 32'd0);
        tick();
        checkOutput("t8_req_drop", 32'(memBus.mem_req), 32'd0);
        checkOutput("t8_err", 32'(fetch_err), 32'd1);
        checkOutput("t8_count", 32'(fetch_count), 32'(expCount));
        applyStimulus(8'h61, 8'h12);
        checkOutput("t8_err_sticky", 32'(fetch_err), 32'd1);
        checkOutput("t8_ir", 32'(ir), 32'h12);
        checkOutput("t8_count2", 32'(fetch_count), 32'(expCount));
`else
        repeat (20) tick();
        checkOutput("t8_req_wait", 32'(memBus.mem_req), 32'd1);
        checkOutput("t8_err", 32'(fetch_err), 32'd0);
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 8'h12;
        tick();
        memBus.mem_ack = 1'b0;
        expCount       = expCount + 8'd1;
        checkOutput("t8_ir", 32'(ir), 32'h12);
        checkOutput("t8_count", 32'(fetch_count), 32'(expCount));
        repeat (3) tick();
        checkOutput("t8_err_after", 32'(fetch_err), 32'd0);
`endif

        // Asynchronous reset in the middle of REQ
        run     = 1'b1;
        pc_addr = 8'h70;
        tick();
        checkOutput("t9_req", 32'(memBus.mem_req), 32'd1);
        #2;
        CLB = 1'b1;
        #1;
        checkOutput("t9_req_off", 32'(memBus.mem_req), 32'd0);
        checkOutput("t9_inc", 32'(IncPC), 32'd0);
        checkOutput("t9_valid", 32'(ir_valid), 32'd0);
        checkOutput("t9_count", 32'(fetch_count), 32'd0);
        checkOutput("t9_err", 32'(fetch_err), 32'd0);
        tick();
        CLB      = 1'b0;
        expCount = 8'd0;

        // Asynchronous reset while IncPC and ir_valid are high
        run     = 1'b1;
        pc_addr = 8'h80;
        tick();
        run              = 1'b0;
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = 8'hE1;
        tick();
        memBus.mem_ack = 1'b0;
        checkOutput("t10_valid", 32'(ir_valid), 32'd1);
        checkOutput("t10_inc", 32'(IncPC), 32'd1);
        #2;
        CLB = 1'b1;
        #1;
        checkOutput("t10_valid_off", 32'(ir_valid), 32'd0);
        checkOutput("t10_inc_off", 32'(IncPC), 32'd0);
        checkOutput("t10_ir", 32'(ir), 32'd0);
        checkOutput("t10_addr", 32'(memBus.mem_addr), 32'd0);
        tick();
        CLB = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch sequencer and instruction register; sits directly downstream of the program counter block.
- Takes the current PC address and issues a read to instruction memory over a req/ack handshake.
- Latches the returned word into the instruction register, splits it into opcode/operand, and presents it to the decoder with a valid/ready handshake.
- Returns an IncPC strobe to the PC; operand nibble feeds the PC's 4-bit jump-target input.

Parameters:
AW, 8, address width (matches PC count width)
IW, 8, instruction width; opcode = ir[IW-1:IW-4], operand = ir[3:0]
INC_HOLD, 2, cycles IncPC is held high per accepted fetch (PC samples on a divided clock)
TIMEOUT_CYCLES, 15, memory wait limit, used only with FETCH_TIMEOUT_EN

Ports:
- CLK  in  1  system clock, all state on posedge
- CLB  in  1  reset, asynchronous, active-high
- run  in  1  enables fetching
- flush  in  1  discard current/in-flight instruction (asserted alongside LoadPC on jumps)
- pc_addr  in  AW  address from PC block
- mem_req  out  1  memory read request
- mem_addr  out  AW  read address, stable while mem_req=1
- mem_rdata  in  IW  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, one-cycle pulse
- IncPC  out  1  increment strobe to PC
- ir  out  IW  instruction register
- opcode  out  4  ir upper nibble
- operand  out  4  ir lower nibble
- ir_valid  out  1  ir holds a valid instruction
- ir_ready  in  1  decoder accepts ir
- fetch_count  out  8  accepted-instruction counter
- fetch_err  out  1  sticky memory timeout flag (tied 0 without feature)

Behaviour:
- Reset (CLB=1, async): state=IDLE; mem_req, mem_addr, IncPC, ir, ir_valid, fetch_count, fetch_err, drop flag and all counters = 0.
- States: IDLE, REQ, HOLD.
- IDLE:
  - if run=1 and flush=0: latch pc_addr into mem_addr, go to REQ.
  - mem_req rises the cycle after run is sampled high.
- REQ:
  - mem_req=1; mem_addr frozen.
  - The request is never withdrawn before mem_ack (except on timeout).
  - On mem_ack with drop=0:
    - ir <= mem_rdata; ir_valid <= 1.
    - IncPC high for exactly INC_HOLD cycles starting next cycle.
    - fetch_count += 1 (wraps 255->0).
    - go to HOLD.
  - On mem_ack with drop=1: data discarded, no IncPC, no count; clear drop; go to IDLE.
- HOLD:
  - ir_valid=1, ir stable.
  - Transfer occurs on a cycle with ir_valid & ir_ready; ir_valid falls next cycle.
  - After transfer: go to REQ if run=1 (new pc_addr latched), else IDLE.
  - A new request is not issued while the IncPC pulse is still active; leave HOLD only after the IncPC counter expires, so pc_addr is already updated.
- Latency: ack to ir_valid is 1 cycle; minimum fetch-to-fetch is max(INC_HOLD+1, 2) cycles plus memory latency.
- flush:
  - IDLE: no effect.
  - REQ: set drop (also when coincident with mem_ack: that data is discarded).
  - HOLD: ir_valid cleared next cycle, IncPC pulse aborted, go to IDLE; ir contents retained but invalid.
  - flush with ir_ready in the same HOLD cycle: flush wins; no transfer is counted as consumed.
- mem_ack outside REQ: ignored.
- run dropping in REQ: the fetch completes; stop in IDLE after the HOLD handoff.
- opcode and operand are continuous slices of ir.
- Reset mid-REQ: mem_req drops asynchronously; the memory side must tolerate the abandoned request.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - Wait counter runs in REQ and clears on entry.
  - If TIMEOUT_CYCLES elapse without mem_ack: mem_req drops, fetch_err <= 1 (sticky until CLB), no IncPC, go to IDLE.
  - Further run-initiated fetches are still allowed.
- Undefined: no counter; REQ waits indefinitely; fetch_err constant 0.

Test Plan:
- Reset, then run=1, pc_addr=0x10, mem_ack after 2 cycles with 0xA5 -> mem_addr=0x10; ir=0xA5, opcode=0xA, operand=0x5; ir_valid=1; IncPC high 2 cycles; fetch_count=1.
- Decoder ir_ready=0 for 5 cycles -> ir_valid and ir hold; no new mem_req until ir_ready=1, then mem_req with updated pc_addr=0x11.
- flush during REQ, then mem_ack with 0x3C -> ir unchanged, ir_valid=0, no IncPC, fetch_count unchanged; next fetch uses new pc_addr=0x40.
- fetch_count preloaded by 255 fetches, one more fetch -> fetch_count=0.
- CLB pulsed mid-REQ -> mem_req, ir_valid, IncPC =0 immediately (asynchronous), state IDLE.
- With FETCH_TIMEOUT_EN, no mem_ack for 15 cycles -> mem_req falls, fetch_err=1 and stays 1 through later successful fetches until CLB.
